// File: rtl/banked_multiport_ram.sv
// banked_multiport_ram
//   Word-addressed data memory shared by several load/store request ports.
//   The store is split into NBANKS independently accessed banks (low address
//   bits select the bank). Each bank grants one port per cycle through its own
//   round-robin pointer. Out-of-range requests bypass arbitration and answer
//   with an error. After reset a sequencer clears every row before any request
//   is accepted.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   init_busy             high while in reset or clearing the array
//   req_valid/req_ready   per-port valid/ready handshake (ready is combinational)
//   req_we                1 = write, 0 = read
//   req_addr/req_wdata    packed per port: port p at [p*AW +: AW] / [p*DW +: DW]
//   rsp_valid             one-cycle pulse after an accepted request
//   rsp_rdata             old word at the address (read-first), 0 on error
//   rsp_err               accepted request had addr >= DEPTH
module banked_multiport_ram #(
  parameter int NPORTS = 4,
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int NBANKS = 4,
  parameter int DEPTH  = 20480
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 init_busy,
  input  logic [NPORTS-1:0]    req_valid,
  output logic [NPORTS-1:0]    req_ready,
  input  logic [NPORTS-1:0]    req_we,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_wdata,
  output logic [NPORTS-1:0]    rsp_valid,
  output logic [NPORTS*DW-1:0] rsp_rdata,
  output logic [NPORTS-1:0]    rsp_err
);

  localparam int ROWS = DEPTH / NBANKS;
  localparam int BW   = $clog2(NBANKS);
  localparam int BIW  = (BW > 0) ? BW : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [RW-1:0]       init_row_r, init_row_s;
  logic                init_busy_s, run_s;

  logic [BIW-1:0]      bank_s      [NPORTS];
  logic [RW-1:0]       row_s       [NPORTS];
  logic [DW-1:0]       wdata_s     [NPORTS];
  logic [NPORTS-1:0]   oor_s;
  logic [NPORTS-1:0]   cand_s      [NBANKS];

  logic [PW-1:0]       ptr_r       [NBANKS];
  logic [NBANKS-1:0]   win_valid_s;
  logic [PW-1:0]       win_port_s  [NBANKS];
  logic [RW-1:0]       win_row_s   [NBANKS];
  logic [NBANKS-1:0]   win_we_s;
  logic [DW-1:0]       win_wdata_s [NBANKS];
  logic [DW-1:0]       rd_word_s   [NBANKS];

  logic [NPORTS-1:0]    ready_s;
  logic [NPORTS-1:0]    rsp_valid_r;
  logic [NPORTS-1:0]    rsp_err_r;
  logic [NPORTS*DW-1:0] rsp_rdata_r;

  // Port index (base + offs) modulo NPORTS; base < NPORTS and offs <= NPORTS.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int offs);
    int sum_v;
    sum_v = int'(base) + offs;
    if (sum_v >= NPORTS) begin
      sum_v = sum_v - NPORTS;
    end else begin
      sum_v = sum_v;
    end
    return PW'(sum_v);
  endfunction

  // State and clear-row register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      init_row_r <= '0;
    end else begin
      state_r    <= state_s;
      init_row_r <= init_row_s;
    end
  end

  // Next state: walk every row once, then stay in RUN until the next reset.
  always_comb begin
    state_s    = state_r;
    init_row_s = init_row_r;
    case (state_r)
      ST_INIT: begin
        if (init_row_r == RW'(ROWS - 1)) begin
          state_s    = ST_RUN;
          init_row_s = '0;
        end else begin
          init_row_s = init_row_r + RW'(1);
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_INIT;
    endcase
  end

  // State decode.
  always_comb begin
    init_busy_s = 1'b1;
    run_s       = 1'b0;
    case (state_r)
      ST_INIT: begin init_busy_s = 1'b1; run_s = 1'b0; end
      ST_RUN:  begin init_busy_s = 1'b0; run_s = 1'b1; end
      default: begin init_busy_s = 1'b1; run_s = 1'b0; end
    endcase
  end

  assign init_busy = init_busy_s;

  // Split each port address into bank, row and range flag.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      bank_s[p]  = (BW > 0) ? req_addr[p*AW +: BIW] : '0;
      row_s[p]   = RW'(req_addr[p*AW +: AW] >> BW);
      wdata_s[p] = req_wdata[p*DW +: DW];
      oor_s[p]   = (req_addr[p*AW +: AW] >= AW'(DEPTH));
    end
  end

  // Per-bank candidate vectors; out-of-range requests never compete.
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      for (int p = 0; p < NPORTS; p++) begin
        cand_s[b][p] = run_s && req_valid[p] && !oor_s[p] && (bank_s[p] == BIW'(b));
      end
    end
  end

  // Round-robin pick: first candidate at or after the bank pointer, wrapping.
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      win_valid_s[b] = 1'b0;
      win_port_s[b]  = '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (!win_valid_s[b] && cand_s[b][wrap_inc(ptr_r[b], i)]) begin
          win_valid_s[b] = 1'b1;
          win_port_s[b]  = wrap_inc(ptr_r[b], i);
        end else begin
          win_port_s[b]  = win_port_s[b];
        end
      end
      win_row_s[b]   = row_s[win_port_s[b]];
      win_we_s[b]    = win_valid_s[b] && req_we[win_port_s[b]];
      win_wdata_s[b] = wdata_s[win_port_s[b]];
    end
  end

  // Ready for bank winners and for any out-of-range request.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      if (!run_s || !req_valid[p]) begin
        ready_s[p] = 1'b0;
      end else if (oor_s[p]) begin
        ready_s[p] = 1'b1;
      end else begin
        ready_s[p] = win_valid_s[bank_s[p]] && (win_port_s[bank_s[p]] == PW'(p));
      end
    end
  end

  assign req_ready = ready_s;

  // Bank storage: the read word is taken before the edge's write lands,
  // which gives read-first behaviour for write responses.
  for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
    logic [DW-1:0] mem_r [ROWS];

    // Clear one row per cycle during INIT, otherwise commit the granted write.
    always_ff @(posedge clock) begin
      if (init_busy_s) begin
        mem_r[init_row_r] <= '0;
      end else if (win_we_s[gb]) begin
        mem_r[win_row_s[gb]] <= win_wdata_s[gb];
      end
    end

    assign rd_word_s[gb] = mem_r[win_row_s[gb]];
  end

  // Round-robin pointers advance past each granted port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBANKS; b++) ptr_r[b] <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (win_valid_s[b]) ptr_r[b] <= wrap_inc(win_port_s[b], 1);
      end
    end
  end

  // Response registers; rdata holds between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= '0;
      rsp_err_r   <= '0;
      rsp_rdata_r <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        rsp_valid_r[p] <= ready_s[p];
        rsp_err_r[p]   <= ready_s[p] & oor_s[p];
        if (ready_s[p]) begin
          rsp_rdata_r[p*DW +: DW] <= oor_s[p] ? '0 : rd_word_s[bank_s[p]];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_banked_multiport_ram.sv
// Self-checking bench for banked_multiport_ram with the default geometry
// (4 ports, 4 banks, 20480 words). A reference model keeps the memory as a
// sparse address->word map and picks each bank's winner as the candidate with
// the smallest round-robin distance from that bank's pointer.
module tb_banked_multiport_ram;

  localparam int NP    = 4;
  localparam int NB    = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 20480;
  localparam int ROWS  = DEPTH / NB;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              init_busy;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata, rsp_rdata;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic        b_valid [NP];
  logic        b_we    [NP];
  logic [31:0] b_addr  [NP];
  logic [31:0] b_wdata [NP];

  logic [31:0]   ref_mem [int];
  int            rr_ptr  [NB];
  logic [NP-1:0] m_ready, m_rsp_valid, m_rsp_err;
  logic [31:0]   m_rsp_rdata [NP];
  logic [NP-1:0] dut_ready_last;
  int            grant_cnt [NP];

  banked_multiport_ram #(
    .NPORTS(NP), .DW(DW), .AW(AW), .NBANKS(NB), .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_cnt++;
    assert (obs === exp) else begin
      errors_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req_valid[p]            = b_valid[p];
      req_we[p]               = b_we[p];
      req_addr[p*AW +: AW]    = b_addr[p];
      req_wdata[p*DW +: DW]   = b_wdata[p];
    end
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) begin
      b_valid[p] = 1'b0; b_we[p] = 1'b0; b_addr[p] = 32'd0; b_wdata[p] = 32'd0;
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    b_valid[p] = 1'b1; b_we[p] = we; b_addr[p] = a; b_wdata[p] = d;
  endtask

  task automatic model_reset();
    ref_mem.delete();
    for (int b = 0; b < NB; b++) rr_ptr[b] = 0;
    m_ready = '0; m_rsp_valid = '0; m_rsp_err = '0;
    for (int p = 0; p < NP; p++) m_rsp_rdata[p] = 32'd0;
  endtask

  function automatic logic [31:0] mem_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  function automatic logic [NP*DW-1:0] m_rdata_packed();
    logic [NP*DW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*DW +: DW] = m_rsp_rdata[p];
    return v;
  endfunction

  // One accept decision for the currently driven requests.
  task automatic model_step();
    logic [NP-1:0] acc;
    int best, bestd, d;
    acc = '0;
    for (int p = 0; p < NP; p++) begin
      if (b_valid[p] && b_addr[p] >= 32'(DEPTH)) acc[p] = 1'b1;
    end
    for (int bk = 0; bk < NB; bk++) begin
      best = -1; bestd = NP;
      for (int p = 0; p < NP; p++) begin
        if (b_valid[p] && b_addr[p] < 32'(DEPTH) && int'(b_addr[p] % 32'(NB)) == bk) begin
          d = (p - rr_ptr[bk] + NP) % NP;
          if (d < bestd) begin bestd = d; best = p; end
        end
      end
      if (best >= 0) begin
        acc[best] = 1'b1;
        rr_ptr[bk] = (best + 1) % NP;
      end
    end
    m_ready = acc;
    for (int p = 0; p < NP; p++) begin
      m_rsp_valid[p] = acc[p];
      m_rsp_err[p]   = 1'b0;
      if (acc[p]) begin
        if (b_addr[p] >= 32'(DEPTH)) begin
          m_rsp_err[p] = 1'b1; m_rsp_rdata[p] = 32'd0;
        end else begin
          m_rsp_rdata[p] = mem_rd(int'(b_addr[p]));
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && b_we[p] && b_addr[p] < 32'(DEPTH)) ref_mem[int'(b_addr[p])] = b_wdata[p];
    end
  endtask

  // Called at posedge+1: drive, check ready, cross one edge, check response.
  task automatic run_cycle(input string tag);
    drive();
    #1;
    model_step();
    dut_ready_last = req_ready;
    check({tag, ":ready"}, 128'(req_ready), 128'(m_ready));
    @(posedge clock); #1;
    check({tag, ":rsp_valid"}, 128'(rsp_valid), 128'(m_rsp_valid));
    check({tag, ":rsp_err"},   128'(rsp_err),   128'(m_rsp_err));
    check({tag, ":rsp_rdata"}, 128'(rsp_rdata), 128'(m_rdata_packed()));
  endtask

  // Counts cycles with init_busy high from posedge+1; bounded.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < ROWS + 100) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 128'(n), 128'(ROWS));
  endtask

  task automatic new_req(input int p);
    b_valid[p] = ($urandom_range(0, 3) != 0);
    b_we[p]    = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 9))
      0:       b_addr[p] = 32'(DEPTH) + $urandom_range(0, 100);
      1:       b_addr[p] = 32'(DEPTH - 1) - $urandom_range(0, 3);
      default: b_addr[p] = $urandom_range(0, 31);
    endcase
    b_wdata[p] = $urandom;
  endtask

  initial begin
    idle_all();
    drive();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset:init_busy", 128'(init_busy), 128'(1'b1));
    check("reset:req_ready", 128'(req_ready), 128'(0));
    check("reset:rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset:rsp_rdata", 128'(rsp_rdata), 128'(0));
    check("reset:rsp_err",   128'(rsp_err),   128'(0));
    reset = 1'b0;
    wait_init("init_len");

    // Freshly cleared words read back zero, one cycle after acceptance.
    set_req(0, 1'b0, 32'd0, 32'd0);
    run_cycle("rd0");
    check("rd0:ready_first", 128'(dut_ready_last[0]), 128'(1'b1));
    check("rd0:data", 128'(rsp_rdata[31:0]), 128'(0));
    set_req(0, 1'b0, 32'd2048, 32'd0);
    run_cycle("rd2048");
    check("rd2048:valid", 128'(rsp_valid[0]), 128'(1'b1));
    set_req(0, 1'b0, 32'd20479, 32'd0);
    run_cycle("rd20479");
    check("rd20479:data", 128'(rsp_rdata[31:0]), 128'(0));

    // Write then read on another port.
    idle_all();
    set_req(0, 1'b1, 32'd4096, 32'hDEADBEEF);
    run_cycle("wr4096");
    check("wr4096:old", 128'(rsp_rdata[31:0]), 128'(0));
    idle_all();
    set_req(3, 1'b0, 32'd4096, 32'd0);
    run_cycle("rd4096");
    check("rd4096:new", 128'(rsp_rdata[127:96]), 128'(32'hDEADBEEF));

    // All ports contend for bank 0.
    idle_all();
    for (int p = 0; p < NP; p++) begin
      set_req(p, 1'b0, 32'(4 * p), 32'd0);
      grant_cnt[p] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      run_cycle("rr");
      for (int p = 0; p < NP; p++) grant_cnt[p] += int'(dut_ready_last[p]);
    end
    for (int p = 0; p < NP; p++) check("rr:grants", 128'(grant_cnt[p]), 128'(2));

    // Distinct banks all served together.
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 32'(p), 32'd0);
    run_cycle("banks");
    check("banks:ready", 128'(dut_ready_last), 128'(4'hF));
    check("banks:valid", 128'(rsp_valid), 128'(4'hF));

    // Out-of-range write is dropped and flagged.
    idle_all();
    set_req(2, 1'b1, 32'd20480, 32'h5);
    run_cycle("oor");
    check("oor:ready", 128'(dut_ready_last[2]), 128'(1'b1));
    check("oor:err",   128'(rsp_err[2]), 128'(1'b1));
    check("oor:data",  128'(rsp_rdata[95:64]), 128'(0));
    set_req(2, 1'b0, 32'd0, 32'd0);
    run_cycle("oor_rd0");
    check("oor_rd0:data", 128'(rsp_rdata[95:64]), 128'(0));

    // Randomized traffic; stalled ports hold their request.
    for (int p = 0; p < NP; p++) new_req(p);
    for (int c = 0; c < 400; c++) begin
      run_cycle("rand");
      for (int p = 0; p < NP; p++) begin
        if (!b_valid[p] || m_ready[p]) new_req(p);
      end
    end

    // Reset with responses outstanding and again mid-INIT.
    idle_all();
    set_req(0, 1'b0, 32'd4096, 32'd0);
    set_req(1, 1'b0, 32'd1, 32'd0);
    run_cycle("pre_rst");
    check("pre_rst:valid", 128'(rsp_valid[1:0]), 128'(2'b11));
    check("pre_rst:data", 128'(rsp_rdata[31:0]), 128'(32'hDEADBEEF));
    idle_all();
    drive();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst:rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst:rsp_rdata", 128'(rsp_rdata), 128'(0));
    check("rst:init_busy", 128'(init_busy), 128'(1'b1));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("mid_init:busy", 128'(init_busy), 128'(1'b1));
    set_req(0, 1'b0, 32'd0, 32'd0);
    drive();
    #1;
    check("mid_init:ready", 128'(req_ready), 128'(0));
    idle_all();
    drive();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_init("reinit_len");
    set_req(0, 1'b0, 32'd4096, 32'd0);
    run_cycle("post_rst");
    check("post_rst:data", 128'(rsp_rdata[31:0]), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
